// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: ld/st info field layout,
// access size encodings, the zero register index and FSM state codes.
`timescale 1ns/1ps
package mem_stage_pkg;

  // Bit positions inside the ld/st info field
  localparam int LSI_SIZE_LO  = 0;
  localparam int LSI_SIZE_HI  = 1;
  localparam int LSI_UNSIGNED = 2;

  // Access size encodings
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Writes to x0 are never committed
  localparam logic [4:0] REG_X0 = 5'd0;

  // Stage FSM encoding
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FULL  = 2'd3;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic for the MEM stage: store strobes and replicated store data,
// load lane selection with sign/zero extension, and misalignment detection.
`timescale 1ns/1ps
module mem_lsu_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LD_ST_INFO_WIDTH = 3
) (
  input  logic [1:0]                  addr_lo,
  input  logic [LD_ST_INFO_WIDTH-1:0] info,
  input  logic                        is_mem,
  input  logic [XLEN-1:0]             rs2,
  input  logic [XLEN-1:0]             rdata,
  output logic [3:0]                  wstrb,
  output logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             ld_data,
  output logic                        misalign
);

  logic [1:0]      size;
  logic            is_unsigned;
  logic [XLEN-1:0] shifted;

  assign size        = info[LSI_SIZE_HI:LSI_SIZE_LO];
  assign is_unsigned = info[LSI_UNSIGNED];

  // Decode size/offset into strobes, store data, extended load data and misalignment
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    wstrb    = 4'hF;
    wdata    = rs2;
    ld_data  = rdata;
    misalign = 1'b0;
    shifted  = rdata >> {addr_lo, 3'b000};
    case (size)
      SIZE_B: begin
        wstrb   = 4'b0001 << addr_lo;
        wdata   = {(XLEN/8){rs2[7:0]}};
        ld_data = {{(XLEN-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      end
      SIZE_H: begin
        wstrb    = 4'b0011 << addr_lo;
        wdata    = {(XLEN/16){rs2[15:0]}};
        ld_data  = {{(XLEN-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
        misalign = is_mem & addr_lo[0];
      end
      default: begin
        misalign = is_mem & (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: accepts EX results over valid/ready, performs data
// memory loads/stores on a req/gnt/rvalid bus, forwards ALU results to EX
// and hands results to WB over valid/ready.
`timescale 1ns/1ps
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN             = 32,
  parameter int LD_ST_INFO_WIDTH = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        EX_valid_i,
  output logic                        MEM_ready_o,
  input  logic [XLEN-1:0]             EX_pc_i,
  input  logic [XLEN-1:0]             EX_alu_res_i,
  input  logic [XLEN-1:0]             EX_rs2_rdata_i,
  input  logic [LD_ST_INFO_WIDTH-1:0] EX_ld_st_info_i,
  input  logic                        EX_op_load_i,
  input  logic                        EX_op_store_i,
  input  logic                        EX_rd_wen_i,
  input  logic [4:0]                  EX_rd_idx_i,
  output logic                        dbus_req_o,
  output logic                        dbus_we_o,
  output logic [XLEN-1:0]             dbus_addr_o,
  output logic [XLEN-1:0]             dbus_wdata_o,
  output logic [3:0]                  dbus_wstrb_o,
  input  logic                        dbus_gnt_i,
  input  logic                        dbus_rvalid_i,
  input  logic [XLEN-1:0]             dbus_rdata_i,
  input  logic                        dbus_err_i,
  output logic                        MEM_rd_wen_o,
  output logic [4:0]                  MEM_rd_idx_o,
  output logic [XLEN-1:0]             MEM_alu_res_o,
  output logic                        MEM_valid_o,
  input  logic                        WB_ready_i,
  output logic [XLEN-1:0]             MEM_pc_o,
  output logic [XLEN-1:0]             MEM_rd_wdata_o,
  output logic                        MEM_wb_wen_o,
  output logic                        MEM_misalign_o,
  output logic                        MEM_bus_err_o
);

  logic [1:0]                  state;
  logic [XLEN-1:0]             pc_q;
  logic [XLEN-1:0]             alu_q;
  logic [XLEN-1:0]             rs2_q;
  logic [LD_ST_INFO_WIDTH-1:0] info_q;
  logic                        load_q;
  logic                        store_q;
  logic                        rd_wen_q;
  logic [4:0]                  rd_idx_q;
  logic [XLEN-1:0]             ld_data_q;
  logic                        misalign_q;
  logic                        bus_err_q;

  logic                        accept;
  logic                        use_held;
  logic                        in_req;
  logic [1:0]                  al_addr_lo;
  logic [LD_ST_INFO_WIDTH-1:0] al_info;
  logic                        al_is_mem;
  logic [3:0]                  al_wstrb;
  logic [XLEN-1:0]             al_wdata;
  logic [XLEN-1:0]             al_ld_data;
  logic                        al_misalign;

  assign MEM_ready_o = (state == ST_EMPTY) || ((state == ST_FULL) && WB_ready_i);
  assign accept      = EX_valid_i && MEM_ready_o;
  assign in_req      = (state == ST_REQ);

  // Accepts only happen in EMPTY/FULL and the bus is only active in REQ/WAIT,
  // so one alignment unit serves both: incoming EX fields for the misalign
  // decision, held fields while the access is in flight.
  assign use_held   = (state == ST_REQ) || (state == ST_WAIT);
  assign al_addr_lo = use_held ? alu_q[1:0] : EX_alu_res_i[1:0];
  assign al_info    = use_held ? info_q : EX_ld_st_info_i;
  assign al_is_mem  = use_held ? (load_q | store_q) : (EX_op_load_i | EX_op_store_i);

  mem_lsu_align #(
    .XLEN             (XLEN),
    .LD_ST_INFO_WIDTH (LD_ST_INFO_WIDTH)
  ) u_align (
    .addr_lo  (al_addr_lo),
    .info     (al_info),
    .is_mem   (al_is_mem),
    .rs2      (rs2_q),
    .rdata    (dbus_rdata_i),
    .wstrb    (al_wstrb),
    .wdata    (al_wdata),
    .ld_data  (al_ld_data),
    .misalign (al_misalign)
  );

  // Stage FSM plus capture of EX fields and of the bus response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_EMPTY;
      pc_q       <= '0;
      alu_q      <= '0;
      rs2_q      <= '0;
      info_q     <= '0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      rd_wen_q   <= 1'b0;
      rd_idx_q   <= '0;
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else if (accept) begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      pc_q       <= EX_pc_i;
      alu_q      <= EX_alu_res_i;
      rs2_q      <= EX_rs2_rdata_i;
      info_q     <= EX_ld_st_info_i;
      load_q     <= EX_op_load_i;
      store_q    <= EX_op_store_i;
      rd_wen_q   <= EX_rd_wen_i;
      rd_idx_q   <= EX_rd_idx_i;
      misalign_q <= al_misalign;
      bus_err_q  <= 1'b0;
      state      <= ((EX_op_load_i || EX_op_store_i) && !al_misalign) ? ST_REQ : ST_FULL;
    end else begin
      case (state)
        ST_REQ: begin
          if (dbus_gnt_i) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Responses outside WAIT are never looked at, which drops stale ones.
          if (dbus_rvalid_i) begin
            state <= ST_FULL;
            if (dbus_err_i) bus_err_q <= 1'b1;
            else if (load_q) ld_data_q <= al_ld_data;
          end
        end
        ST_FULL: begin
          if (WB_ready_i) state <= ST_EMPTY;
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are quiet outside REQ
  assign dbus_req_o   = in_req;
  assign dbus_we_o    = in_req && store_q;
  assign dbus_addr_o  = in_req ? {alu_q[XLEN-1:2], 2'b00} : '0;
  assign dbus_wdata_o = (in_req && store_q) ? al_wdata : '0;
  assign dbus_wstrb_o = (in_req && store_q) ? al_wstrb : 4'h0;

  // Forwarding: ALU results only; loads are handled by the load-use stall
  assign MEM_rd_wen_o  = rd_wen_q && !load_q && (state != ST_EMPTY);
  assign MEM_rd_idx_o  = rd_idx_q;
  assign MEM_alu_res_o = alu_q;

  // WB interface
  assign MEM_valid_o    = (state == ST_FULL);
  assign MEM_pc_o       = pc_q;
  assign MEM_rd_wdata_o = load_q ? ld_data_q : alu_q;
  assign MEM_wb_wen_o   = (state == ST_FULL) && rd_wen_q && !misalign_q && !bus_err_q &&
                          (rd_idx_q != REG_X0);
  assign MEM_misalign_o = misalign_q;
  assign MEM_bus_err_o  = bus_err_q;

endmodule
